// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for the debouncer
package debounce_pkg;

  localparam int DEFAULT_STABLE_TICKS = 4;
  localparam int DEFAULT_TICK_DIV     = 1;
  localparam int SYNC_STAGES          = 2;

  // Counter width for a 0..n-1 counter; never returns zero so n=1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running sampling tick, one pulse every TICK_DIV clocks
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // With TICK_DIV=1 the count is pinned at 0 and tick stays high.
  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a raw input, with edge pulses
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic                   tick;
  logic [CW-1:0]          stable_cnt;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign sync = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
    end
  end

  // Any return of sync to q clears the count, so bounces never accumulate.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      q          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == q) begin
        stable_cnt <= '0;
      end else if (tick) begin
        if (stable_cnt == LAST) begin
          q          <= sync;
          rise       <= sync;
          fall       <= ~sync;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync at TICK_DIV 1 and 4
module tb_debounce_sync;

  localparam int ST = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic din     = 1'b0;
  logic q_a, rise_a, fall_a;
  logic q_b, rise_b, fall_b;

  int total = 0;
  int bad   = 0;
  int rise_cnt_a = 0;
  int fall_cnt_a = 0;
  int pulse_cnt_a = 0;

  // Model state: instance 0 runs TICK_DIV=1, instance 1 runs TICK_DIV=4.
  logic m_s1[2], m_s2[2], m_q[2], m_r[2], m_f[2];
  int   m_run[2];
  int   m_edges[2];

  debounce_sync #(.STABLE_TICKS(ST), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .din(din), .q(q_a), .rise(rise_a), .fall(fall_a)
  );

  debounce_sync #(.STABLE_TICKS(ST), .TICK_DIV(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .din(din), .q(q_b), .rise(rise_b), .fall(fall_b)
  );

  always #5 clk = ~clk;

  function automatic int td_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic dq(input int i);
    return (i == 0) ? q_a : q_b;
  endfunction

  function automatic logic dr(input int i);
    return (i == 0) ? rise_a : rise_b;
  endfunction

  function automatic logic df(input int i);
    return (i == 0) ? fall_a : fall_b;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  // Ticks fall on every TICK_DIV-th edge since reset release; q follows sync
  // once sync has disagreed with q across ST consecutive ticks.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_s1[i] = 0; m_s2[i] = 0; m_q[i] = 0; m_r[i] = 0; m_f[i] = 0;
        m_run[i] = 0; m_edges[i] = 0;
      end else begin
        bit is_tick;
        is_tick = ((m_edges[i] % td_of(i)) == td_of(i) - 1);
        m_edges[i]++;
        m_r[i] = 0;
        m_f[i] = 0;
        if (m_s2[i] == m_q[i]) begin
          m_run[i] = 0;
        end else if (is_tick) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            m_q[i]   = m_s2[i];
            m_r[i]   = m_s2[i];
            m_f[i]   = !m_s2[i];
            m_run[i] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = din;
      end
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      rise_cnt_a += int'(rise_a);
      fall_cnt_a += int'(fall_a);
      pulse_cnt_a += int'(rise_a | fall_a);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("q%0d", i), dq(i), m_q[i]);
        chk($sformatf("rise%0d", i), dr(i), m_r[i]);
        chk($sformatf("fall%0d", i), df(i), m_f[i]);
        chk($sformatf("excl%0d", i), dr(i) & df(i), 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic measure_b(input string name);
    int n;
    n = 0;
    while (q_b !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk({name, "_timeout"}, logic'(n < 40), 1'b1);
    chk_range({name, "_latency"}, n - 2, 12, 16);
  endtask

  initial begin
    int n;
    int rb, fb, pb;

    // Reset state
    din = 1'b0;
    do_reset();
    chk("rst_q", q_a, 1'b0);
    chk("rst_rise", rise_a, 1'b0);
    chk("rst_fall", fall_a, 1'b0);
    chk("rst_qb", q_b, 1'b0);

    // Clean 0->1: q and rise appear after E0+5, rise gone after E0+6
    pb = pulse_cnt_a;
    din = 1'b1;
    step(5);
    chk("lat_q_early", q_a, 1'b0);
    step(1);
    chk("lat_q", q_a, 1'b1);
    chk("lat_rise", rise_a, 1'b1);
    step(1);
    chk("lat_rise_off", rise_a, 1'b0);
    chk("lat_q_hold", q_a, 1'b1);
    chk("lat_no_fall", logic'(fall_cnt_a == 0), 1'b1);
    din = 1'b0;
    step(8);
    chk("lat_q_back", q_a, 1'b0);

    // Short pulses of 1, 2, 3 clocks never reach q
    do_reset();
    pb = pulse_cnt_a;
    for (int w = 1; w <= 3; w++) begin
      din = 1'b1;
      step(w);
      din = 1'b0;
      step(3);
    end
    step(6);
    chk("glitch_q", q_a, 1'b0);
    chk("glitch_qb", q_b, 1'b0);
    chk("glitch_pulses", logic'(pulse_cnt_a == pb), 1'b1);

    // TICK_DIV=4: latency window, then a mid-count bounce restarts the count
    do_reset();
    din = 1'b1;
    measure_b("div4");
    din = 1'b0;
    n = 0;
    while (q_b !== 1'b0 && n < 40) begin
      step(1);
      n++;
    end
    chk("div4_fall_timeout", logic'(n < 40), 1'b1);
    din = 1'b1;
    step(6);
    din = 1'b0;
    step(10);
    chk("bounce_q_low", q_b, 1'b0);
    din = 1'b1;
    measure_b("bounce");

    // Reset mid-count discards the partial count
    din = 1'b0;
    do_reset();
    din = 1'b1;
    step(4);
    reset_n = 1'b0;
    step(1);
    chk("midrst_q", q_a, 1'b0);
    chk("midrst_rise", rise_a, 1'b0);
    chk("midrst_fall", fall_a, 1'b0);
    reset_n = 1'b1;
    step(5);
    chk("midrst_q_early", q_a, 1'b0);
    step(1);
    chk("midrst_q", q_a, 1'b1);
    chk("midrst_rise_again", rise_a, 1'b1);

    // Reset pulse wholly between edges has no effect
    step(4);
    reset_n = 1'b0;
    #8;
    reset_n = 1'b1;
    step(1);
    chk("glitch_rst_q", q_a, 1'b1);

    // Full toggle gives exactly one rise and one fall
    din = 1'b0;
    do_reset();
    rb = rise_cnt_a;
    fb = fall_cnt_a;
    din = 1'b1;
    step(10);
    din = 1'b0;
    step(10);
    chk("toggle_one_rise", logic'(rise_cnt_a - rb == 1), 1'b1);
    chk("toggle_one_fall", logic'(fall_cnt_a - fb == 1), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter STABLE_TICKS, default 4: number of consecutive ticks a changed input must hold before q follows it; legal range 2..65535.
REQ-002 Parameter TICK_DIV, default 1: clocks per sampling tick; 1 means every clock is a tick; legal range 1..65535.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 Port din  input  1  raw asynchronous input (button/switch); may glitch or bounce at any time.
REQ-006 Port q  output  1  debounced, synchronised level; feeds the downstream d_ff d input.
REQ-007 Port rise  output  1  one-clock pulse in the cycle q goes 0->1.
REQ-008 Port fall  output  1  one-clock pulse in the cycle q goes 1->0.

Function
REQ-009 din SHALL pass through a 2-stage flip-flop synchroniser (s1, s2) before any other logic uses it; s2 is "sync".
REQ-010 The tick generator SHALL count 0..TICK_DIV-1 and assert tick for one clock when the count equals TICK_DIV-1, then wrap to 0; with TICK_DIV=1, tick is constantly 1.
REQ-011 When sync == q, the stability counter SHALL clear to 0 on that edge, regardless of tick.
REQ-012 When sync != q and tick=1 and counter == STABLE_TICKS-1, then on that edge:
  - q SHALL load sync.
  - the counter SHALL clear to 0.
REQ-013 When sync != q and tick=1 and counter < STABLE_TICKS-1, the counter SHALL increment by 1.
REQ-014 When sync != q and tick=0, the counter SHALL hold its value.
REQ-015 Stability counter width SHALL be $clog2(STABLE_TICKS); it never exceeds STABLE_TICKS-1, and no wrap beyond that is permitted.
REQ-016 With TICK_DIV=1, a din change settled before rising edge E0 SHALL appear on q at the (2+STABLE_TICKS)-th rising edge counting E0 as the first.
REQ-017 Glitches and bounce SHALL leave q unchanged: any pulse on sync shorter than STABLE_TICKS ticks resets the counter; the counter does not accumulate across bounces.
REQ-018 rise and fall SHALL be registered outputs, asserted in exactly the same cycle q changes, and each high for exactly one clock.
REQ-019 rise and fall SHALL never both be 1.
REQ-020 The tick generator SHALL run freely and is not re-phased by din activity.

Reset
REQ-021 While reset_n=0 at a rising edge, the following SHALL be set to 0 on that edge:
  - s1, s2, tick counter, stability counter;
  - q, rise, fall.
REQ-022 Reset SHALL take priority over every other update.
REQ-023 Reset asserted mid-count SHALL discard the partial count; q=0 on the following cycle even if din=1.
REQ-024 After reset_n returns to 1 with din held at 1, q SHALL rise following the REQ-016 latency, with rise pulsing once.
REQ-025 Reset SHALL have no asynchronous path; a reset_n pulse between clock edges with no rising edge while low has no effect.

Structure
REQ-026 Shared package debounce_pkg SHALL hold:
  - DEFAULT_STABLE_TICKS=4
  - DEFAULT_TICK_DIV=1
  - SYNC_STAGES=2
REQ-027 Sub-module tick_gen (parameter TICK_DIV; ports clk, reset_n, tick) SHALL implement REQ-010 and be instantiated once.
REQ-028 The synchroniser, stability counter, q register and edge pulses SHALL reside in debounce_sync.

Verification
REQ-029 STABLE_TICKS=4, TICK_DIV=1: reset, then din 0->1 just before edge E0 -> q=1 and rise=1 after edge E0+5, rise=0 after E0+6, fall never asserted.
REQ-030 STABLE_TICKS=4, TICK_DIV=1: din=1 pulses of 1, 2 and 3 clocks separated by 3 low clocks -> q stays 0; rise and fall stay 0.
REQ-031 STABLE_TICKS=4, TICK_DIV=4: din 0->1 held -> q rises 12-16 clocks after sync goes high; a 10-clock bounce-low mid-count restarts the count.
REQ-032 Reset mid-count: din=1, reset_n=0 for one edge after counter reaches 2 -> q, rise, fall = 0 next cycle; q rises 6 edges after reset_n=1 (TICK_DIV=1).
REQ-033 Reset between edges: reset_n low from 1 ns after an edge to 1 ns before the next edge -> no state change; full toggle sequence 0->1->0 -> exactly one rise and one fall pulse.
